// File: rtl/mm_stream_if.sv
// mm_stream_if: byte-stream input and output valid/ready handshakes
interface mm_stream_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
  modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/mm_stream_core.sv
// mm_stream_core: streamed NxN matrix multiply C = A x B over byte handshakes.
// Define MM_SIGNED_EN for two's-complement elements and sign-extended results.
module mm_stream_core #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic     clk,
  input  logic     rst,
  mm_stream_if.slave s,
  output logic     busy,
  output logic     done
);
  localparam int BI = DW / 8;
  localparam int RW = 2 * DW + $clog2(N);
  localparam int OB = (RW + 7) / 8;
  localparam int EW = $clog2(N * N);
  localparam int RC = $clog2(N);
  localparam int KW = $clog2(N + 1);
  localparam int BW = $clog2(OB);
  localparam logic [1:0] S_LA = 2'd0, S_LB = 2'd1, S_CP = 2'd2, S_SD = 2'd3;
  logic [1:0]    r_st;
  logic [DW-1:0] r_a [N*N];
  logic [DW-1:0] r_b [N*N];
  logic [RW-1:0] r_c [N*N];
  logic [7:0]    r_sh;
  logic [EW-1:0] r_idx, r_oe;
  logic          r_ib, r_ov;
  logic [RC-1:0] r_row, r_col;
  logic [KW-1:0] r_k;
  logic [RW-1:0] r_acc;
  logic [BW-1:0] r_ob;
  logic [7:0]    r_od;
  logic          w_in_fire, w_out_fire, w_last_byte, w_last_el, w_last_ob, w_last_oe, w_mac_wr, w_rc_end;
  logic [DW-1:0] w_elem, w_av, w_bv;
  logic [EW-1:0] w_ai, w_bi, w_ci, w_se;
  logic [BW-1:0] w_sb;
  logic [2*DW-1:0] w_prod;
  logic [RW-1:0] w_pext, w_cv;
  logic [OB*8-1:0] w_ext;
  logic [7:0]    w_ob;
  assign s.in_ready  = ~r_st[1];
  assign s.out_valid = r_ov;
  assign s.out_data  = r_od;
  assign busy        = r_st[1];
  assign w_in_fire   = s.in_valid & ~r_st[1];
  assign w_out_fire  = (r_st == S_SD) & r_ov & s.out_ready;
  assign w_last_byte = r_ib == 1'(BI - 1);
  assign w_last_el   = r_idx == EW'(N * N - 1);
  assign w_elem      = DW'({r_sh, s.in_data});
  assign w_mac_wr    = (r_st == S_CP) && (r_k == KW'(N));
  assign w_rc_end    = r_col == RC'(N - 1);
  assign w_ai = EW'(int'(r_row) * N + int'(r_k));
  assign w_bi = EW'(int'(r_k) * N + int'(r_col));
  assign w_ci = EW'(int'(r_row) * N + int'(r_col));
  assign w_av = r_a[w_ai];
  assign w_bv = r_b[w_bi];
  assign w_last_ob = r_ob == BW'(OB - 1);
  assign w_last_oe = r_oe == EW'(N * N - 1);
  // next output position; outside SEND this points at the first byte of C[0]
  assign w_se = (r_st == S_SD && w_last_ob) ? r_oe + 1'b1 : (r_st == S_SD) ? r_oe : '0;
  assign w_sb = (r_st == S_SD && !w_last_ob) ? r_ob + 1'b1 : '0;
  assign w_cv = r_c[w_se];
`ifdef MM_SIGNED_EN
  assign w_prod = {{DW{w_av[DW-1]}}, w_av} * {{DW{w_bv[DW-1]}}, w_bv};
  assign w_pext = {{(RW-2*DW){w_prod[2*DW-1]}}, w_prod};
  assign w_ext  = {{(OB*8-RW){w_cv[RW-1]}}, w_cv};
`else
  assign w_prod = {{DW{1'b0}}, w_av} * {{DW{1'b0}}, w_bv};
  assign w_pext = {{(RW-2*DW){1'b0}}, w_prod};
  assign w_ext  = {{(OB*8-RW){1'b0}}, w_cv};
`endif
  assign w_ob = 8'(w_ext >> (8 * (OB - 1 - int'(w_sb))));
  always_ff @(posedge clk) begin
    if (w_in_fire && w_last_byte && r_st == S_LA) r_a[r_idx] <= w_elem;
    if (w_in_fire && w_last_byte && r_st == S_LB) r_b[r_idx] <= w_elem;
    if (w_mac_wr) r_c[w_ci] <= r_acc;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st  <= S_LA;
      r_sh  <= '0;
      r_idx <= '0;
      r_ib  <= 1'b0;
      r_row <= '0;
      r_col <= '0;
      r_k   <= '0;
      r_acc <= '0;
      r_oe  <= '0;
      r_ob  <= '0;
      r_ov  <= 1'b0;
      r_od  <= 8'h00;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_in_fire) begin
        r_sh <= s.in_data;
        r_ib <= w_last_byte ? 1'b0 : r_ib + 1'b1;
        if (w_last_byte) r_idx <= w_last_el ? '0 : r_idx + 1'b1;
        if (w_last_byte && w_last_el) r_st <= (r_st == S_LA) ? S_LB : S_CP;
      end
      if (w_mac_wr) begin
        r_k   <= '0;
        r_col <= w_rc_end ? '0 : r_col + 1'b1;
        if (w_rc_end) r_row <= (r_row == RC'(N - 1)) ? '0 : r_row + 1'b1;
        if (w_rc_end && r_row == RC'(N - 1)) begin
          r_st <= S_SD;
          r_ov <= 1'b1;
          r_od <= w_ob;
          r_oe <= '0;
          r_ob <= '0;
        end
      end else if (r_st == S_CP) begin
        r_acc <= (r_k == '0 ? '0 : r_acc) + w_pext;
        r_k   <= r_k + 1'b1;
      end
      if (w_out_fire && w_last_ob && w_last_oe) begin
        r_st <= S_LA;
        r_ov <= 1'b0;
        r_od <= 8'h00;
        done <= 1'b1;
      end else if (w_out_fire) begin
        r_oe <= w_se;
        r_ob <= w_sb;
        r_od <= w_ob;
      end
    end
  end
endmodule

// File: tb/tb_mm_stream_core.sv
// tb_mm_stream_core: directed checks of the 4x4/8-bit and 2x2/16-bit builds
module tb_mm_stream_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mm_stream_if s0 ();
  mm_stream_if s1 ();
  logic busy0, done0, busy1, done1;
  mm_stream_core #(.N(4), .DW(8))  u0 (.clk(clk), .rst(rst), .s(s0.slave), .busy(busy0), .done(done0));
  mm_stream_core #(.N(2), .DW(16)) u1 (.clk(clk), .rst(rst), .s(s1.slave), .busy(busy1), .done(done1));
  int checks = 0;
  int errors = 0;
  logic [7:0]  ma [16];
  logic [7:0]  mb [16];
  logic [23:0] mc [16];
  logic [39:0] c16;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send0(input logic [7:0] v);
    @(negedge clk);
    s0.in_valid = 1'b1;
    s0.in_data  = v;
    @(posedge clk);
  endtask
  task automatic send1(input logic [7:0] v);
    @(negedge clk);
    s1.in_valid = 1'b1;
    s1.in_data  = v;
    @(posedge clk);
  endtask
  task automatic get0(output logic [7:0] b, output logic ok);
    ok = 1'b0;
    b  = 8'h00;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      s0.out_ready = 1'b1;
      if (s0.out_valid) begin
        b  = s0.out_data;
        ok = 1'b1;
      end
    end
    if (ok) @(posedge clk);
  endtask
  task automatic get1(output logic [7:0] b, output logic ok);
    ok = 1'b0;
    b  = 8'h00;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      s1.out_ready = 1'b1;
      if (s1.out_valid) begin
        b  = s1.out_data;
        ok = 1'b1;
      end
    end
    if (ok) @(posedge clk);
  endtask
  task automatic frame0(input logic lat);
    int cnt;
    logic [7:0] d, x;
    logic ok;
    for (int i = 0; i < 16; i++) send0(ma[i]);
    for (int i = 0; i < 16; i++) send0(mb[i]);
    #1 s0.in_valid = 1'b0;
    chk("in_ready_compute", s0.in_ready, 0);
    chk("busy_compute", busy0, 1);
    cnt = 0;
    while (!s0.out_valid && cnt < 300) begin
      @(posedge clk);
      #1 cnt++;
    end
    chk("out_valid_rise", s0.out_valid, 1);
    if (lat) begin
      chk("latency", cnt, 80);
      d = s0.out_data;
      repeat (10) begin
        @(negedge clk);
        chk("bp_valid", s0.out_valid, 1);
        chk("bp_data", s0.out_data, d);
      end
    end
    for (int e = 0; e < 16; e++)
      for (int b = 0; b < 3; b++) begin
        get0(x, ok);
        chk("rx_timeout", ok, 1);
        chk($sformatf("c%0d_byte%0d", e, b), x, mc[e][(2-b)*8 +: 8]);
      end
    #1;
    chk("done_pulse", done0, 1);
    chk("in_ready_done", s0.in_ready, 1);
    chk("busy_done", busy0, 0);
    chk("out_valid_done", s0.out_valid, 0);
    s0.out_ready = 1'b0;
    @(posedge clk);
    #1 chk("done_one_cycle", done0, 0);
  endtask
  initial begin
    int cnt;
    logic [7:0] x;
    logic ok;
    s0.in_valid = 1'b0; s0.in_data = 8'h00; s0.out_ready = 1'b0;
    s1.in_valid = 1'b0; s1.in_data = 8'h00; s1.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", s0.in_ready, 1);
    chk("rst_out_valid", s0.out_valid, 0);
    chk("rst_out_data", s0.out_data, 8'h00);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_in_ready16", s1.in_ready, 1);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 7; i++) send0(8'h55);
    @(negedge clk);
    s0.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", s0.in_ready, 1);
    chk("midrst_out_valid", s0.out_valid, 0);
    chk("midrst_busy", busy0, 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ma[i] = (i / 4 == i % 4) ? 8'd1 : 8'd0;
      mb[i] = 8'(i + 1);
      mc[i] = 24'(i + 1);
    end
    frame0(1'b1);
    for (int i = 0; i < 16; i++) begin
      ma[i] = 8'hFF;
      mb[i] = 8'hFF;
`ifdef MM_SIGNED_EN
      mc[i] = 24'h000004;
`else
      mc[i] = 24'h03F804;
`endif
    end
    frame0(1'b0);
    for (int i = 0; i < 16; i++) begin
      ma[i] = 8'hFF;
      mb[i] = 8'h01;
`ifdef MM_SIGNED_EN
      mc[i] = 24'hFFFFFC;
`else
      mc[i] = 24'h0003FC;
`endif
    end
    frame0(1'b0);
`ifdef MM_SIGNED_EN
    c16 = 40'h0000000002;
`else
    c16 = 40'h01FFFC0002;
`endif
    for (int i = 0; i < 16; i++) send1(8'hFF);
    #1 s1.in_valid = 1'b0;
    chk("busy16", busy1, 1);
    cnt = 0;
    while (!s1.out_valid && cnt < 100) begin
      @(posedge clk);
      #1 cnt++;
    end
    chk("latency16", cnt, 12);
    for (int e = 0; e < 4; e++)
      for (int b = 0; b < 5; b++) begin
        get1(x, ok);
        chk("rx16_timeout", ok, 1);
        chk($sformatf("c16_%0d_byte%0d", e, b), x, c16[(4-b)*8 +: 8]);
      end
    #1 chk("done16", done1, 1);
    s1.out_ready = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mm_stream_core.md
# mm_stream_core

Parametrised successor to the fixed 4x4 8-bit UART matrix multiplier: computes C = A x B for N x N matrices of DW-bit elements, fed and drained as byte streams over valid/ready handshakes. It sits between the `uart_rx` and `uart_tx` byte interfaces, with a thin handshake adapter, and runs on the divided UART clock domain. It adds back-pressure, a generic dimension and width, and optional signed arithmetic.

## Interface
- `N`, 4: matrix dimension; range 2..8.
- `DW`, 8: element width in bits; must be 8 or 16. BI = DW/8 input bytes per element.
- Derived, not overridable:
  - RW = 2*DW + clog2(N): exact result width.
  - OB = ceil(RW/8): output bytes per element.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_data`  in  8  input byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts a byte; transfer occurs when `in_valid && in_ready`.
- `out_data`  out  8  result byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts a byte; transfer occurs when `out_valid && out_ready`.
- `busy`  out  1  high in COMPUTE and SEND.
- `done`  out  1  one-cycle pulse after the last output byte transfers.

## Operation
- States: LOAD_A -> LOAD_B -> COMPUTE -> SEND -> LOAD_A.
- LOAD_A / LOAD_B:
  - `in_ready` = 1.
  - Accept N*N elements, row-major, each BI bytes MSB first.
  - Element index and byte counters advance only on a transfer.
  - After the last byte of A, move to LOAD_B; after the last byte of B, move to COMPUTE.
- COMPUTE:
  - `in_ready` = 0; input bytes are not consumed.
  - One MAC per cycle. For each (r,c) in row-major order, the accumulator clears, then N cycles of acc += A[r][k]*B[k][c].
  - One write cycle stores the RW-bit result. Total N*N*(N+1) cycles.
  - Result width RW is exact, so overflow is impossible.
- SEND:
  - Emits C row-major, each element as OB bytes MSB first.
  - The value is extended to OB*8 bits: zero-extended unsigned, sign-extended when signed.
  - After the final transfer: pulse `done`, return to LOAD_A, start the next frame.
- A and B storage is not cleared between frames; every frame overwrites all entries.

## Timing
- Reset values:
  - `in_ready` = 1, `out_valid` = 0, `out_data` = 0x00, `busy` = 0, `done` = 0.
  - State is LOAD_A; all counters are 0.
- Input:
  - One byte per cycle maximum; zero-bubble streaming is supported.
  - `in_ready` falls in the cycle after the edge that accepted the last B byte.
- Compute latency: the edge accepting the last B byte enters COMPUTE; `out_valid` first rises exactly N*N*(N+1) edges later (80 for N=4).
- Output:
  - `out_data` is registered.
  - While `out_valid && !out_ready`, `out_data` and `out_valid` hold stable.
  - With `out_ready` held high, one byte transfers per cycle, no bubbles.
- `done`: high for the cycle after the last output transfer, coincident with the return to LOAD_A; `in_ready` = 1 in that same cycle.
- Reset mid-operation, in any state: immediately return to reset values. A partially loaded or partially sent frame is discarded; the next byte accepted is A[0][0] MSB.
- `in_valid` during COMPUTE/SEND: ignored; the byte is not consumed.
- `out_ready` outside SEND: ignored.

## Configuration
- `MM_SIGNED_EN` defined:
  - Elements are two's complement.
  - Products and accumulation are signed.
  - Output is sign-extended to OB*8 bits.
- `MM_SIGNED_EN` undefined: all arithmetic unsigned; output zero-extended.

## Test plan
- Identity, N=4, DW=8, unsigned:
  - Stimulus: A = I, B = 1..16.
  - Response: 48 bytes, each element 0x00,0x00,v for v = 1..16 in order; `done` pulses once.
- Max values, unsigned, N=4:
  - Stimulus: A = B = all 0xFF.
  - Response: every element 0x03,0xF8,0x04 (260100).
- Sign handling, A = all 0xFF, B = all 0x01:
  - With `MM_SIGNED_EN`: every element 0xFF,0xFF,0xFC (-4).
  - Without it: every element 0x00,0x03,0xFC (1020).
- Latency and back-pressure:
  - Stream 32 bytes back-to-back; check `out_valid` rises exactly 80 edges after the last accept.
  - Hold `out_ready` low for 10 cycles; check `out_data` and `out_valid` stay constant.
- Reset mid-load: send 7 bytes, pulse `rst`, then send the full identity frame; output must match the identity case.
- DW=16, N=2, unsigned:
  - Stimulus: A = B = all 0xFFFF (16 bytes in).
  - Response: RW = 33, OB = 5; every element 0x01,0xFF,0xFC,0x00,0x02.
